// File: rtl/crc32_serial_checker.sv
// Serial CRC-32 frame checker: data bits then 32-bit CRC field MSB-first, one bit per bit_valid.
// Latency: done/crc_ok/crc_err register 1 cycle after the 32nd CRC bit; no backpressure, bits consumed on arrival.
// Optional CRC_CAPTURE_EN macro adds rx_crc/calc_crc capture outputs.
module crc32_serial_checker #(
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'h00000000,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bit_valid,
  input  logic             crc_in,
  input  logic             d_finish,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
`ifdef CRC_CAPTURE_EN
  output logic [31:0]      rx_crc,
  output logic [31:0]      calc_crc,
`endif
  output logic [CNT_W-1:0] data_bits
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [31:0] crc_reg;
  logic [4:0]  cnt;
  logic        mismatch;
  logic [31:0] crc_data;
  logic        mis_next;

  assign busy = (state == S_DATA) || (state == S_CHECK);

  // Register value after this cycle's data bit (held when no bit is offered).
  always_comb begin
    crc_data = crc_reg;
    if (bit_valid) begin
      crc_data = {crc_reg[30:0], 1'b0} ^ ((crc_reg[31] ^ crc_in) ? POLY : 32'h0);
    end
    mis_next = mismatch | (crc_in != crc_reg[31]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      crc_reg   <= INIT;
      cnt       <= 5'd0;
      mismatch  <= 1'b0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      data_bits <= '0;
`ifdef CRC_CAPTURE_EN
      rx_crc    <= 32'h0;
      calc_crc  <= 32'h0;
`endif
    end else if (load) begin
      state     <= S_DATA;
      crc_reg   <= INIT;
      cnt       <= 5'd0;
      mismatch  <= 1'b0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      data_bits <= '0;
`ifdef CRC_CAPTURE_EN
      rx_crc    <= 32'h0;
      calc_crc  <= 32'h0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_DATA: begin
          if (bit_valid && (data_bits != {CNT_W{1'b1}})) begin
            data_bits <= data_bits + CNT_W'(1);
          end
          if (d_finish) begin
            crc_reg <= crc_data ^ XOROUT;
            cnt     <= 5'd0;
            state   <= S_CHECK;
`ifdef CRC_CAPTURE_EN
            calc_crc <= crc_data ^ XOROUT;
`endif
          end else begin
            crc_reg <= crc_data;
          end
        end
        S_CHECK: begin
          if (bit_valid) begin
            // Expected CRC streams out of the MSB while the received field streams in.
            mismatch <= mis_next;
            crc_reg  <= {crc_reg[30:0], 1'b0};
            cnt      <= cnt + 5'd1;
`ifdef CRC_CAPTURE_EN
            rx_crc   <= {rx_crc[30:0], crc_in};
`endif
            if (cnt == 5'd31) begin
              state   <= S_DONE;
              done    <= 1'b1;
              crc_ok  <= ~mis_next;
              crc_err <= mis_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
